// File: rtl/cpu_pkg.sv
// Shared CPU definitions: loader state encodings, instruction geometry and
// the load/store opcodes also decoded by the control FSM.
package cpu_pkg;

  localparam int INST_W     = 16;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;

  localparam logic [3:0] OP_LOAD     = 4'b0111;
  localparam logic [3:0] OP_STORE    = 4'b1101;
  localparam logic [3:0] OP_LOAD_IMM = 4'b1110;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HALF  = 2'd1,
    S_FULL  = 2'd2,
    S_EXEC  = 2'd3
  } load_state_t;

  function automatic logic [3:0] opcode_of(input logic [INST_W-1:0] inst);
    return inst[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/inst_loader_if.sv
// Signals between the user panel, the instruction loader and the control FSM.
interface inst_loader_if;
  import cpu_pkg::*;

  // Signalling: btn_edge is a one-cycle strobe per accepted press; inst_done is a
  // level held while a complete instruction waits; exec_busy is a level from the
  // control FSM and is sampled only on a btn_edge cycle (or while executing).
  logic              btn_in;
  logic [7:0]        sw_in;
  logic              exec_busy;
  logic              btn_edge;
  logic              inst_done;
  logic [INST_W-1:0] instr;
  logic [3:0]        opcode;
  logic [1:0]        load_state;

  modport slave (
    input  btn_in, sw_in, exec_busy,
    output btn_edge, inst_done, instr, opcode, load_state
  );

  modport master (
    output btn_in, sw_in, exec_busy,
    input  btn_edge, inst_done, instr, opcode, load_state
  );

endinterface

// File: rtl/btn_conditioner.sv
// Push-button synchroniser, optional debouncer and rising-edge strobe.
// Debounce counter exists only when INST_LOADER_DEBOUNCE_EN is defined.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_edge
);

  logic       sync_q1;
  logic       sync_q2;
  logic       level;
  logic       level_d;
  logic       armed;
  logic [1:0] warm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_in;
      sync_q2 <= sync_q1;
    end
  end

  // Edges are armed only once the synchronised button has been seen released
  // after reset, so a button held through reset release never strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm     <= 2'b00;
      armed    <= 1'b0;
      level_d  <= 1'b0;
      btn_edge <= 1'b0;
    end else begin
      warm     <= {warm[0], 1'b1};
      armed    <= armed | (warm[1] & ~sync_q2);
      level_d  <= level;
      btn_edge <= armed & level & ~level_d;
    end
  end

`ifdef INST_LOADER_DEBOUNCE_EN
  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [15:0] cnt;
  logic        deb;

  // Counts consecutive samples that disagree with the debounced level; the
  // count never exceeds CNT_LAST, so it cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (sync_q2 == deb) begin
      cnt <= '0;
    end else if (cnt >= CNT_LAST) begin
      deb <= sync_q2;
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  assign level = deb;
`else
  assign level = sync_q2;

  // Hardware-debounced button: the debounce length has no effect here.
  if (DEBOUNCE_CYCLES == 0) begin : g_debounce_unused
  end
`endif

endmodule

// File: rtl/inst_loader.sv
// Instruction loader: assembles a 16-bit instruction from two switch bytes on
// debounced button presses; the third press triggers execution.
module inst_loader
  import cpu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int          INST_W          = cpu_pkg::INST_W
) (
  input logic          clk,
  input logic          rst_n,
  inst_loader_if.slave bus
);

  load_state_t       state;
  load_state_t       next_state;
  logic              seen;
  logic              cap_lo;
  logic              cap_hi;
  logic              btn_edge;
  logic              inst_done_q;
  logic [INST_W-1:0] instr_q;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_in  (bus.btn_in),
    .btn_edge(btn_edge)
  );

  always_comb begin
    next_state = state;
    cap_lo     = 1'b0;
    cap_hi     = 1'b0;
    case (state)
      S_EMPTY: if (btn_edge && !bus.exec_busy) begin
        cap_lo     = 1'b1;
        next_state = S_HALF;
      end
      S_HALF: if (btn_edge && !bus.exec_busy) begin
        cap_hi     = 1'b1;
        next_state = S_FULL;
      end
      S_FULL: if (btn_edge) next_state = S_EXEC;
      // Stay at least two cycles so the FSM has left IDLE before we release.
      S_EXEC: if (!bus.exec_busy && seen) next_state = S_EMPTY;
      default: next_state = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_EMPTY;
      seen        <= 1'b0;
      inst_done_q <= 1'b0;
    end else begin
      state       <= next_state;
      seen        <= (state == S_EXEC) && (next_state == S_EXEC);
      inst_done_q <= (next_state == S_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
    end else begin
      if (cap_lo) instr_q[7:0]        <= bus.sw_in;
      if (cap_hi) instr_q[INST_W-1:8] <= bus.sw_in;
    end
  end

  assign bus.btn_edge   = btn_edge;
  assign bus.inst_done  = inst_done_q;
  assign bus.instr      = instr_q;
  assign bus.opcode     = opcode_of(instr_q);
  assign bus.load_state = state;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader; works with or without
// INST_LOADER_DEBOUNCE_EN defined.
module tb_inst_loader;

  localparam int DB = 16;
`ifdef INST_LOADER_DEBOUNCE_EN
  localparam int LAT = DB + 3;
  localparam int BOUNCE_EDGES = 0;
`else
  localparam int LAT = 3;
  localparam int BOUNCE_EDGES = 3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  inst_loader_if bus ();

  inst_loader #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_cnt = 0;
  logic done_prev = 1'b0;
  logic [15:0] exp_q[$];

  // Scoreboard: each completed instruction must match the next expected one.
  always @(negedge clk) begin
    if (bus.btn_edge === 1'b1) edge_cnt++;
    if (rst_n && bus.inst_done === 1'b1 && done_prev !== 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got instr %h, expected no completion", bus.instr);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (bus.instr !== e) begin
          n_bad++;
          $display("FAIL sb_instr: got %h expected %h", bus.instr, e);
        end
      end
    end
    done_prev = bus.inst_done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] sw, output int edges);
    int start;
    start = edge_cnt;
    bus.sw_in  = sw;
    bus.btn_in = 1'b1;
    repeat (LAT + 6) tick();
    bus.btn_in = 1'b0;
    repeat (LAT + 6) tick();
    edges = edge_cnt - start;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_cmp += 5;
    if (bus.btn_edge !== 1'b0) begin n_bad++; $display("FAIL rst_btn_edge: got %b expected 0", bus.btn_edge); end
    if (bus.inst_done !== 1'b0) begin n_bad++; $display("FAIL rst_inst_done: got %b expected 0", bus.inst_done); end
    if (bus.instr !== 16'h0000) begin n_bad++; $display("FAIL rst_instr: got %h expected 0000", bus.instr); end
    if (bus.opcode !== 4'h0) begin n_bad++; $display("FAIL rst_opcode: got %h expected 0", bus.opcode); end
    if (bus.load_state !== 2'd0) begin n_bad++; $display("FAIL rst_state: got %0d expected 0", bus.load_state); end
    rst_n = 1'b1;
    repeat (5) tick();
  endtask

  // Bouncy press while exec_busy is high, so nothing is captured.
  task automatic test_bounce();
    int start, first_k, after;
    bus.exec_busy = 1'b1;
    start = edge_cnt;
    for (int i = 0; i < 6; i++) begin
      bus.btn_in = (i % 2 == 0);
      repeat (3) tick();
    end
    n_cmp++;
    if (edge_cnt - start != BOUNCE_EDGES) begin
      n_bad++; $display("FAIL bounce_edges: got %0d expected %0d", edge_cnt - start, BOUNCE_EDGES);
    end
    bus.btn_in = 1'b1;
    first_k = 0;
    after = 0;
    for (int k = 1; k <= LAT + 6; k++) begin
      tick();
      if (bus.btn_edge === 1'b1) begin
        after++;
        if (first_k == 0) first_k = k;
      end
    end
    n_cmp += 2;
    if (first_k != LAT) begin n_bad++; $display("FAIL edge_latency: got edge %0d expected %0d", first_k, LAT); end
    if (after != 1) begin n_bad++; $display("FAIL held_edges: got %0d expected 1", after); end
    start = edge_cnt;
    bus.btn_in = 1'b0;
    repeat (LAT + 6) tick();
    n_cmp += 3;
    if (edge_cnt != start) begin n_bad++; $display("FAIL release_edges: got %0d expected 0", edge_cnt - start); end
    if (bus.load_state !== 2'd0) begin n_bad++; $display("FAIL busy_drop_state: got %0d expected 0", bus.load_state); end
    if (bus.instr !== 16'h0000) begin n_bad++; $display("FAIL busy_drop_instr: got %h expected 0000", bus.instr); end
    bus.exec_busy = 1'b0;
  endtask

  task automatic test_load();
    int edges;
    press(8'h34, edges);
    n_cmp += 3;
    if (edges != 1) begin n_bad++; $display("FAIL lo_edges: got %0d expected 1", edges); end
    if (bus.load_state !== 2'd1) begin n_bad++; $display("FAIL lo_state: got %0d expected 1", bus.load_state); end
    if (bus.instr[7:0] !== 8'h34) begin n_bad++; $display("FAIL lo_byte: got %h expected 34", bus.instr[7:0]); end
    exp_q.push_back(16'h1234);
    press(8'h12, edges);
    n_cmp += 4;
    if (bus.instr !== 16'h1234) begin n_bad++; $display("FAIL full_instr: got %h expected 1234", bus.instr); end
    if (bus.opcode !== 4'h1) begin n_bad++; $display("FAIL full_opcode: got %h expected 1", bus.opcode); end
    if (bus.inst_done !== 1'b1) begin n_bad++; $display("FAIL full_done: got %b expected 1", bus.inst_done); end
    if (bus.load_state !== 2'd2) begin n_bad++; $display("FAIL full_state: got %0d expected 2", bus.load_state); end
    // exec_busy rising in S_FULL without a press changes nothing.
    bus.exec_busy = 1'b1;
    repeat (4) tick();
    bus.exec_busy = 1'b0;
    tick();
    n_cmp++;
    if (bus.load_state !== 2'd2) begin n_bad++; $display("FAIL full_busy_state: got %0d expected 2", bus.load_state); end
  endtask

  task automatic test_exec();
    int edges;
    logic found;
    found = 1'b0;
    bus.btn_in = 1'b1;
    for (int k = 1; k <= LAT + 6; k++) begin
      tick();
      if (!found && bus.btn_edge === 1'b1) begin
        found = 1'b1;
        n_cmp += 2;
        if (bus.inst_done !== 1'b1) begin n_bad++; $display("FAIL exec_pulse_done: got %b expected 1", bus.inst_done); end
        if (bus.load_state !== 2'd2) begin n_bad++; $display("FAIL exec_pulse_state: got %0d expected 2", bus.load_state); end
        bus.exec_busy = 1'b1;
        tick();
        n_cmp += 3;
        if (bus.inst_done !== 1'b0) begin n_bad++; $display("FAIL exec_done_fall: got %b expected 0", bus.inst_done); end
        if (bus.load_state !== 2'd3) begin n_bad++; $display("FAIL exec_state: got %0d expected 3", bus.load_state); end
        if (bus.instr !== 16'h1234) begin n_bad++; $display("FAIL exec_instr: got %h expected 1234", bus.instr); end
      end
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL exec_timeout: got no btn_edge expected one within %0d cycles", LAT + 6); end
    bus.btn_in = 1'b0;
    repeat (LAT + 6) tick();
    press(8'hAA, edges);
    press(8'h55, edges);
    repeat (20) tick();
    n_cmp += 3;
    if (edges != 1) begin n_bad++; $display("FAIL exec_press_edges: got %0d expected 1", edges); end
    if (bus.load_state !== 2'd3) begin n_bad++; $display("FAIL exec_hold_state: got %0d expected 3", bus.load_state); end
    if (bus.instr !== 16'h1234) begin n_bad++; $display("FAIL exec_hold_instr: got %h expected 1234", bus.instr); end
    bus.exec_busy = 1'b0;
    tick();
    n_cmp += 2;
    if (bus.load_state !== 2'd0) begin n_bad++; $display("FAIL exec_release_state: got %0d expected 0", bus.load_state); end
    if (bus.instr !== 16'h1234) begin n_bad++; $display("FAIL exec_release_instr: got %h expected 1234", bus.instr); end
  endtask

  task automatic test_busy_drop();
    int edges;
    press(8'h56, edges);
    bus.exec_busy = 1'b1;
    press(8'hFF, edges);
    n_cmp += 3;
    if (edges != 1) begin n_bad++; $display("FAIL half_busy_edges: got %0d expected 1", edges); end
    if (bus.load_state !== 2'd1) begin n_bad++; $display("FAIL half_busy_state: got %0d expected 1", bus.load_state); end
    if (bus.instr !== 16'h1256) begin n_bad++; $display("FAIL half_busy_instr: got %h expected 1256", bus.instr); end
    bus.exec_busy = 1'b0;
  endtask

  task automatic test_reset_mid();
    int start, edges;
    bus.btn_in = 1'b1;
    repeat (LAT - 1) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp += 5;
    if (bus.btn_edge !== 1'b0) begin n_bad++; $display("FAIL arst_btn_edge: got %b expected 0", bus.btn_edge); end
    if (bus.inst_done !== 1'b0) begin n_bad++; $display("FAIL arst_inst_done: got %b expected 0", bus.inst_done); end
    if (bus.instr !== 16'h0000) begin n_bad++; $display("FAIL arst_instr: got %h expected 0000", bus.instr); end
    if (bus.opcode !== 4'h0) begin n_bad++; $display("FAIL arst_opcode: got %h expected 0", bus.opcode); end
    if (bus.load_state !== 2'd0) begin n_bad++; $display("FAIL arst_state: got %0d expected 0", bus.load_state); end
    repeat (3) tick();
    rst_n = 1'b1;
    start = edge_cnt;
    repeat (LAT + 10) tick();
    n_cmp += 2;
    if (edge_cnt != start) begin n_bad++; $display("FAIL held_reset_edges: got %0d expected 0", edge_cnt - start); end
    if (bus.load_state !== 2'd0) begin n_bad++; $display("FAIL held_reset_state: got %0d expected 0", bus.load_state); end
    bus.btn_in = 1'b0;
    repeat (LAT + 6) tick();
    press(8'h9A, edges);
    n_cmp += 3;
    if (edges != 1) begin n_bad++; $display("FAIL repress_edges: got %0d expected 1", edges); end
    if (bus.load_state !== 2'd1) begin n_bad++; $display("FAIL repress_state: got %0d expected 1", bus.load_state); end
    if (bus.instr !== 16'h009A) begin n_bad++; $display("FAIL repress_instr: got %h expected 009a", bus.instr); end
  endtask

  // Execute with exec_busy low: S_EXEC must last exactly two cycles.
  task automatic exec_quick();
    logic found;
    found = 1'b0;
    bus.btn_in = 1'b1;
    for (int k = 1; k <= LAT + 6; k++) begin
      tick();
      if (!found && bus.btn_edge === 1'b1) begin
        found = 1'b1;
        n_cmp++;
        if (bus.load_state !== 2'd2) begin n_bad++; $display("FAIL quick_pulse_state: got %0d expected 2", bus.load_state); end
        tick();
        n_cmp++;
        if (bus.load_state !== 2'd3) begin n_bad++; $display("FAIL quick_exec1: got %0d expected 3", bus.load_state); end
        tick();
        n_cmp++;
        if (bus.load_state !== 2'd3) begin n_bad++; $display("FAIL quick_exec2: got %0d expected 3", bus.load_state); end
        tick();
        n_cmp++;
        if (bus.load_state !== 2'd0) begin n_bad++; $display("FAIL quick_empty: got %0d expected 0", bus.load_state); end
      end
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL quick_timeout: got no btn_edge expected one within %0d cycles", LAT + 6); end
    bus.btn_in = 1'b0;
    repeat (LAT + 6) tick();
  endtask

  task automatic test_back_to_back();
    int edges;
    logic [7:0] lo, hi;
    hi = 8'($urandom_range(0, 255));
    exp_q.push_back({hi, 8'h9A});
    press(hi, edges);
    exec_quick();
    for (int i = 0; i < 2; i++) begin
      lo = 8'($urandom_range(0, 255));
      hi = 8'($urandom_range(0, 255));
      exp_q.push_back({hi, lo});
      press(lo, edges);
      press(hi, edges);
      n_cmp += 2;
      if (bus.opcode !== hi[7:4]) begin n_bad++; $display("FAIL b2b_opcode: got %h expected %h", bus.opcode, hi[7:4]); end
      if (bus.load_state !== 2'd2) begin n_bad++; $display("FAIL b2b_state: got %0d expected 2", bus.load_state); end
      exec_quick();
    end
  endtask

  initial begin
    bus.btn_in    = 1'b0;
    bus.sw_in     = 8'h00;
    bus.exec_busy = 1'b0;
    test_reset();
    test_bounce();
    test_load();
    test_exec();
    test_busy_drop();
    test_reset_mid();
    test_back_to_back();
    repeat (2) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL sb_leftover: got %0d pending expected 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
